// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU op codes, opcode constants and decode/forwarding selects
package riscv_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_SLT = 4'b1000,
    ALU_EQ  = 4'b1011,
    ALU_NE  = 4'b1100,
    ALU_LT  = 4'b1101,
    ALU_GE  = 4'b1110,
    ALU_LUI = 4'b1111
  } alu_op_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  typedef enum logic [1:0] {FWD_RF, FWD_EXM, FWD_WB} fwd_sel_e;
  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
  typedef enum logic [2:0] {B_RS2, B_IMM, B_SHAMT, B_FOUR, B_UPPER} b_sel_e;
  typedef struct packed {
    alu_op_e op;
    a_sel_e  a_sel;
    b_sel_e  b_sel;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    is_branch;
    logic    illegal;
  } dec_t;
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: opcode/funct3/funct7[5] to ALU op, operand selects and control flags
module alu_op_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output dec_t       o_dec
);
  logic w_alt;
  logic w_shift;
  // funct7[5] selects SUB/SRA for R-type, but only SRAI among immediates
  assign w_alt = i_funct7_5 & (i_opcode == OP_R | i_funct3 == 3'b101);
  assign w_shift = i_funct3[1:0] == 2'b01;
  // Decode table; illegal encodings collapse to a flagless ADD
  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OP_R, OP_IMM: begin
        case (i_funct3)
          3'b000: o_dec.op = w_alt ? ALU_SUB : ALU_ADD;
          3'b111: o_dec.op = ALU_AND;
          3'b110: o_dec.op = ALU_OR;
          3'b100: o_dec.op = ALU_XOR;
          3'b001: o_dec.op = ALU_SLL;
          3'b101: o_dec.op = w_alt ? ALU_SRA : ALU_SRL;
          3'b010: o_dec.op = ALU_SLT;
          default: o_dec.illegal = 1'b1;
        endcase
        o_dec.b_sel = i_opcode == OP_R ? B_RS2 : w_shift ? B_SHAMT : B_IMM;
        o_dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        o_dec.b_sel = B_IMM;
        o_dec.mem_read = 1'b1;
        o_dec.reg_write = 1'b1;
      end
      OP_STORE: begin
        o_dec.b_sel = B_IMM;
        o_dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        case (i_funct3)
          3'b000: o_dec.op = ALU_EQ;
          3'b001: o_dec.op = ALU_NE;
          3'b100: o_dec.op = ALU_LT;
          3'b101: o_dec.op = ALU_GE;
          default: o_dec.illegal = 1'b1;
        endcase
        o_dec.is_branch = 1'b1;
      end
      OP_LUI: begin
        o_dec.op = ALU_LUI;
        o_dec.a_sel = A_ZERO;
        o_dec.b_sel = B_UPPER;
        o_dec.reg_write = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        o_dec.a_sel = A_PC;
        o_dec.b_sel = B_FOUR;
        o_dec.reg_write = 1'b1;
      end
      default: o_dec.illegal = 1'b1;
    endcase
    if (o_dec.illegal) begin
      o_dec.op = ALU_ADD;
      o_dec.reg_write = 1'b0;
      o_dec.mem_read = 1'b0;
      o_dec.mem_write = 1'b0;
      o_dec.is_branch = 1'b0;
    end
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register with decode, operand forwarding, stall and flush
module alu_issue_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [6:0]               id_opcode,
  input  logic [2:0]               id_funct3,
  input  logic                     id_funct7_5,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic                     exm_reg_write,
  input  logic [REG_ADDR_W-1:0]    exm_rd,
  input  logic [DATA_WIDTH-1:0]    exm_result,
  input  logic                     wb_reg_write,
  input  logic [REG_ADDR_W-1:0]    wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     ex_valid,
  output logic [OPCODE_LENGTH-1:0] ex_operation,
  output logic [DATA_WIDTH-1:0]    ex_src_a,
  output logic [DATA_WIDTH-1:0]    ex_src_b,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_is_branch,
  output logic                     ex_illegal
);
  dec_t                  w_dec;
  fwd_sel_e              w_sel_a;
  fwd_sel_e              w_sel_b;
  logic [DATA_WIDTH-1:0] w_fa;
  logic [DATA_WIDTH-1:0] w_fb;
  logic [DATA_WIDTH-1:0] w_src_a;
  logic [DATA_WIDTH-1:0] w_src_b;
  logic                  r_valid;
  logic [OPCODE_LENGTH-1:0] r_op;
  logic [DATA_WIDTH-1:0] r_src_a;
  logic [DATA_WIDTH-1:0] r_src_b;
  logic [DATA_WIDTH-1:0] r_store;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_rw;
  logic                  r_mr;
  logic                  r_mw;
  logic                  r_br;
  logic                  r_ill;
  // Youngest producer wins; x0 is hardwired and never forwarded
  function automatic fwd_sel_e fwd(input logic [REG_ADDR_W-1:0] rs);
    return (rs == '0) ? FWD_RF :
           (exm_reg_write && exm_rd == rs) ? FWD_EXM :
           (wb_reg_write && wb_rd == rs) ? FWD_WB : FWD_RF;
  endfunction
  alu_op_decoder u_dec (
    .i_opcode  (id_opcode),
    .i_funct3  (id_funct3),
    .i_funct7_5(id_funct7_5),
    .o_dec     (w_dec)
  );
  // Forwarding muxes and operand selection
  always_comb begin
    w_sel_a = fwd(id_rs1);
    w_sel_b = fwd(id_rs2);
    w_fa = w_sel_a == FWD_EXM ? exm_result : w_sel_a == FWD_WB ? wb_result : id_rs1_data;
    w_fb = w_sel_b == FWD_EXM ? exm_result : w_sel_b == FWD_WB ? wb_result : id_rs2_data;
    w_src_a = w_dec.a_sel == A_PC ? id_pc : w_dec.a_sel == A_ZERO ? '0 : w_fa;
    w_src_b = w_dec.b_sel == B_IMM   ? id_imm :
              w_dec.b_sel == B_SHAMT ? {{(DATA_WIDTH-5){1'b0}}, id_imm[4:0]} :
              w_dec.b_sel == B_FOUR  ? DATA_WIDTH'(4) :
              w_dec.b_sel == B_UPPER ? id_imm >> 12 : w_fb;
  end
  // Pipeline register: reset > flush > stall > load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_src_a <= '0;
      r_src_b <= '0;
      r_store <= '0;
      r_rd    <= '0;
      r_rw    <= 1'b0;
      r_mr    <= 1'b0;
      r_mw    <= 1'b0;
      r_br    <= 1'b0;
      r_ill   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_rw    <= 1'b0;
      r_mr    <= 1'b0;
      r_mw    <= 1'b0;
      r_br    <= 1'b0;
      r_ill   <= 1'b0;
    end else if (!stall) begin
      r_valid <= id_valid;
      r_op    <= OPCODE_LENGTH'(w_dec.op);
      r_src_a <= w_src_a;
      r_src_b <= w_src_b;
      r_store <= w_fb;
      r_rd    <= id_rd;
      r_rw    <= id_valid & w_dec.reg_write & (id_rd != '0);
      r_mr    <= id_valid & w_dec.mem_read;
      r_mw    <= id_valid & w_dec.mem_write;
      r_br    <= id_valid & w_dec.is_branch;
      r_ill   <= id_valid & w_dec.illegal;
    end
  end
  assign ex_valid      = r_valid;
  assign ex_operation  = r_op;
  assign ex_src_a      = r_src_a;
  assign ex_src_b      = r_src_b;
  assign ex_store_data = r_store;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_rw;
  assign ex_mem_read   = r_mr;
  assign ex_mem_write  = r_mw;
  assign ex_is_branch  = r_br;
  assign ex_illegal    = r_ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench with a behavioural model of the issue stage
module tb_alu_issue_stage;
  logic        clk = 0;
  logic        reset = 1;
  logic        id_valid, id_funct7_5, exm_reg_write, wb_reg_write, stall, flush;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data, exm_result, wb_result;
  logic [4:0]  id_rs1, id_rs2, id_rd, exm_rd, wb_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_illegal;
  logic [3:0]  ex_operation;
  logic [31:0] ex_src_a, ex_src_b, ex_store_data;
  logic [4:0]  ex_rd;

  typedef struct packed {
    logic v; logic [3:0] op; logic [31:0] a, b, sd; logic [4:0] rd;
    logic rw, mr, mw, br, ill;
  } exp_t;

  exp_t st, q[$];
  int   vecs = 0, errs = 0;
  bit   run = 1;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
    .exm_result(exm_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_operation(ex_operation), .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_is_branch(ex_is_branch),
    .ex_illegal(ex_illegal)
  );

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return rf;
    if (exm_reg_write && exm_rd == rs) return exm_result;
    if (wb_reg_write && wb_rd == rs) return wb_result;
    return rf;
  endfunction

  function automatic exp_t model();
    exp_t e = '0;
    logic [31:0] fa = fwd(id_rs1, id_rs1_data);
    logic [31:0] fb = fwd(id_rs2, id_rs2_data);
    logic alu = id_opcode == 7'b0110011 || id_opcode == 7'b0010011;
    logic f7 = id_funct7_5 && (id_opcode == 7'b0110011 || id_funct3 == 3'b101);
    e.v = id_valid; e.rd = id_rd; e.sd = fb; e.a = fa; e.b = fb;
    if (alu) begin
      case (id_funct3)
        3'd0: e.op = f7 ? 4'd1 : 4'd0;
        3'd7: e.op = 4'd2;
        3'd6: e.op = 4'd3;
        3'd4: e.op = 4'd4;
        3'd1: e.op = 4'd5;
        3'd5: e.op = f7 ? 4'd7 : 4'd6;
        3'd2: e.op = 4'd8;
        default: e.ill = 1;
      endcase
      if (id_opcode == 7'b0010011)
        e.b = (id_funct3 == 3'd1 || id_funct3 == 3'd5) ? {27'd0, id_imm[4:0]} : id_imm;
      e.rw = 1;
    end else if (id_opcode == 7'b0000011) begin
      e.b = id_imm; e.mr = 1; e.rw = 1;
    end else if (id_opcode == 7'b0100011) begin
      e.b = id_imm; e.mw = 1;
    end else if (id_opcode == 7'b1100011) begin
      case (id_funct3)
        3'd0: e.op = 4'd11;
        3'd1: e.op = 4'd12;
        3'd4: e.op = 4'd13;
        3'd5: e.op = 4'd14;
        default: e.ill = 1;
      endcase
      e.br = 1;
    end else if (id_opcode == 7'b0110111) begin
      e.op = 4'd15; e.a = 0; e.b = id_imm / 4096; e.rw = 1;
    end else if (id_opcode == 7'b1101111 || id_opcode == 7'b1100111) begin
      e.a = id_pc; e.b = 4; e.rw = 1;
    end else e.ill = 1;
    if (e.ill) begin e.op = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; end
    if (id_rd == 0) e.rw = 0;
    if (!id_valid) begin e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.ill = 0; end
    return e;
  endfunction

  // Advance the model for the coming edge, queue the expectation, move to next negedge
  task automatic cyc();
    if (reset) st = '0;
    else if (flush) begin st.v = 0; st.rw = 0; st.mr = 0; st.mw = 0; st.br = 0; st.ill = 0; end
    else if (!stall) st = model();
    q.push_back(st);
    @(negedge clk);
  endtask

  task automatic clr();
    id_valid = 0; id_opcode = 0; id_funct3 = 0; id_funct7_5 = 0; id_pc = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_data = 0; id_rs2_data = 0;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0; wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    stall = 0; flush = 0;
  endtask

  task automatic ins(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                     input logic [31:0] imm, input logic [31:0] v1, input logic [31:0] v2);
    id_valid = 1; id_opcode = op; id_funct3 = f3; id_funct7_5 = f7;
    id_rs1 = r1; id_rs2 = r2; id_rd = d; id_imm = imm; id_rs1_data = v1; id_rs2_data = v2;
  endtask

  function automatic string show(input exp_t x);
    return $sformatf("v=%0d op=%h a=%h b=%h sd=%h rd=%0d rw/mr/mw/br/ill=%b%b%b%b%b",
                     x.v, x.op, x.a, x.b, x.sd, x.rd, x.rw, x.mr, x.mw, x.br, x.ill);
  endfunction

  // Monitor: compare DUT outputs against the queued expectation after every edge
  always @(posedge clk) begin
    #1;
    if (run) begin
      exp_t a, e;
      logic bad;
      a = {ex_valid, ex_operation, ex_src_a, ex_src_b, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_illegal};
      vecs++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL scoreboard_underflow at %0t: got %s", $time, show(a));
      end else begin
        e = q.pop_front();
        bad = a.v !== e.v || a.rw !== e.rw || a.mr !== e.mr || a.mw !== e.mw ||
              a.br !== e.br || a.ill !== e.ill;
        if (e.v)
          bad = bad || a.op !== e.op || a.sd !== e.sd || a.rd !== e.rd ||
                (!e.ill && (a.a !== e.a || a.b !== e.b));
        if (bad) begin
          errs++;
          $display("FAIL ex_out at %0t: got %s want %s", $time, show(a), show(e));
        end
      end
    end
  end

  initial begin
    logic [6:0] ops [10];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b1101111, 7'b1100111, 7'b0000000, 7'b1110011};
    st = '0;
    clr();
    cyc(); cyc();
    reset = 0;
    // add x3,x1,x2
    ins(7'b0110011, 3'd0, 0, 1, 2, 3, 0, 5, 7); cyc();
    // forwarding priority on rs1
    ins(7'b0110011, 3'd0, 0, 1, 2, 3, 0, 32'h11, 32'h22);
    exm_reg_write = 1; exm_rd = 1; exm_result = 32'h100;
    wb_reg_write = 1; wb_rd = 1; wb_result = 32'h200; cyc();
    exm_reg_write = 0; cyc();
    id_rs1 = 0; exm_reg_write = 1; exm_rd = 0; wb_rd = 0; cyc();
    clr();
    // srai, sub
    ins(7'b0010011, 3'd5, 1, 4, 0, 5, 32'h405, 32'h80000000, 0); cyc();
    ins(7'b0110011, 3'd0, 1, 6, 7, 5, 0, 100, 30); cyc();
    // lui, jal
    ins(7'b0110111, 3'd0, 0, 0, 0, 8, 32'h12345000, 0, 0); cyc();
    ins(7'b1101111, 3'd0, 0, 0, 0, 1, 32'h800, 0, 0); id_pc = 32'h40; cyc();
    // stall with changing inputs, then stall+flush
    ins(7'b0110011, 3'd0, 0, 1, 2, 9, 0, 3, 4); cyc();
    stall = 1;
    ins(7'b0110011, 3'd4, 0, 2, 3, 10, 0, 77, 88); cyc();
    ins(7'b0000011, 3'd2, 0, 5, 6, 11, 16, 99, 1); cyc();
    flush = 1; cyc();
    clr();
    ins(7'b0100011, 3'd2, 0, 1, 2, 0, 8, 32'h1000, 32'hdead); cyc();
    // asynchronous reset mid-stream
    ins(7'b0110011, 3'd7, 0, 1, 2, 4, 0, 32'hf0, 32'h3c);
    reset = 1;
    #1;
    vecs++;
    if ({ex_valid, ex_operation, ex_src_a, ex_src_b, ex_store_data, ex_rd, ex_reg_write,
         ex_mem_read, ex_mem_write, ex_is_branch, ex_illegal} !== '0) begin
      errs++;
      $display("FAIL async_reset: got v=%0d op=%h a=%h b=%h want all zero",
               ex_valid, ex_operation, ex_src_a, ex_src_b);
    end
    cyc();
    reset = 0;
    // bltu illegal, beq with equal forwarded operands
    ins(7'b1100011, 3'd6, 0, 1, 2, 0, 32'h10, 1, 2); cyc();
    ins(7'b1100011, 3'd0, 0, 1, 2, 0, 32'h10, 1, 2);
    exm_reg_write = 1; exm_rd = 1; exm_result = 32'h55;
    wb_reg_write = 1; wb_rd = 2; wb_result = 32'h55; cyc();
    clr();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      id_valid = $urandom_range(0, 7) != 0;
      id_opcode = ops[$urandom_range(0, 9)];
      id_funct3 = 3'($urandom); id_funct7_5 = 1'($urandom);
      id_pc = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_rs1_data = $urandom; id_rs2_data = $urandom;
      exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
      wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_result = $urandom;
      stall = $urandom_range(0, 5) == 0;
      flush = $urandom_range(0, 9) == 0;
      cyc();
    end
    run = 0;
    vecs++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
